// File: rtl/arm_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_pipe_pkg
// Description : Shared types and helpers for the 5-stage ARM pipeline control.
// Revision    : 1.0 - initial release
// ============================================================================
package arm_pipe_pkg;

  localparam int REG_IDX_W = 4;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hctl_state_t;

  // True when a read source operand matches a producing stage's destination
  function automatic logic reg_hit(input logic                 use_src,
                                   input logic [REG_IDX_W-1:0] src,
                                   input logic [REG_IDX_W-1:0] dst);
    return use_src && (src == dst);
  endfunction

endpackage : arm_pipe_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] cnt_q;

  // Synchronous clear, then count until saturated
  always_ff @(posedge clk) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign q_o = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline sequencer: RAW stalls, branch flushes, SRAM wait
//               freeze with timeout, and saturating stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int FWD_EN      = 1,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_src1_i,
  input  logic [REG_IDX_W-1:0] id_src2_i,
  input  logic                 id_use_src1_i,
  input  logic                 id_use_src2_i,
  input  logic [REG_IDX_W-1:0] exe_dest_i,
  input  logic                 exe_wb_en_i,
  input  logic                 exe_mem_r_en_i,
  input  logic [REG_IDX_W-1:0] mem_dest_i,
  input  logic                 mem_wb_en_i,
  input  logic                 br_taken_i,
  input  logic                 mem_req_i,
  input  logic                 mem_ready_i,
  output logic                 freeze_fe_o,
  output logic                 bubble_idex_o,
  output logic                 flush_o,
  output logic                 freeze_all_o,
  output logic                 mem_err_o,
  output logic [CNT_W-1:0]     stall_cnt_o,
  output logic [CNT_W-1:0]     flush_cnt_o
);

  // Timeout counter must be able to hold MEM_TIMEOUT itself
  localparam int                TCNT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(MEM_TIMEOUT);
  localparam logic              FWD      = (FWD_EN != 0);

  hctl_state_t       state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              mem_err_q, mem_err_d;

  logic w_hit_exe;
  logic w_hit_mem;
  logic w_hazard;
  logic w_run_rules;

  assign w_hit_exe = reg_hit(id_use_src1_i, id_src1_i, exe_dest_i) |
                     reg_hit(id_use_src2_i, id_src2_i, exe_dest_i);
  assign w_hit_mem = reg_hit(id_use_src1_i, id_src1_i, mem_dest_i) |
                     reg_hit(id_use_src2_i, id_src2_i, mem_dest_i);

  // With forwarding only a load in EXE cannot be bypassed in time
  assign w_hazard = FWD ? (w_hit_exe & exe_wb_en_i & exe_mem_r_en_i)
                        : ((w_hit_exe & exe_wb_en_i) | (w_hit_mem & mem_wb_en_i));

  // State, timeout counter and sticky error register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      tcnt_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Next-state and control decode; a freeze masks every other control
  always_comb begin
    state_d       = state_q;
    tcnt_d        = tcnt_q;
    mem_err_d     = mem_err_q;
    freeze_all_o  = 1'b0;
    freeze_fe_o   = 1'b0;
    bubble_idex_o = 1'b0;
    flush_o       = 1'b0;
    w_run_rules   = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_req_i && !mem_ready_i) begin
          freeze_all_o = 1'b1;
          state_d      = MEM_WAIT;
          tcnt_d       = TCNT_W'(1);
        end else begin
          w_run_rules = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready_i) begin
          state_d     = RUN;
          tcnt_d      = '0;
          w_run_rules = 1'b1;
        end else if (tcnt_q == TCNT_MAX) begin
          // Give up on the access so the core can trap instead of hanging
          mem_err_d   = 1'b1;
          state_d     = RUN;
          tcnt_d      = '0;
          w_run_rules = 1'b1;
        end else begin
          freeze_all_o = 1'b1;
          tcnt_d       = tcnt_q + TCNT_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        tcnt_d  = '0;
      end
    endcase

    // A taken branch squashes the hazarding instruction, so it wins
    if (w_run_rules) begin
      if (br_taken_i) begin
        flush_o = 1'b1;
      end else if (w_hazard) begin
        freeze_fe_o   = 1'b1;
        bubble_idex_o = 1'b1;
      end
    end
  end

  assign mem_err_o = mem_err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (freeze_fe_o | freeze_all_o),
    .q_o   (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (flush_o),
    .q_o   (flush_cnt_o)
  );

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Two instances share the
//               stimulus: A (forwarding, short timeout, 4-bit counters) and
//               B (no forwarding, default timeout and counter width).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       u1;
    logic       u2;
    logic [3:0] ed;
    logic       ewb;
    logic       eld;
    logic [3:0] md;
    logic       mwb;
    logic       br;
    logic       req;
    logic       rdy;
  } stim_t;

  // Expected controls packed as {freeze_fe, bubble_idex, flush, freeze_all}
  typedef struct packed {
    logic       chk;
    logic [3:0] a;
    logic [3:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic id_use_src1, id_use_src2, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic br_taken, mem_req, mem_ready;

  logic a_ffe, a_bub, a_fl, a_fa, a_err;
  logic [3:0] a_scnt, a_fcnt;
  logic b_ffe, b_bub, b_fl, b_fa, b_err;
  logic [15:0] b_scnt, b_fcnt;

  int   n_run  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.FWD_EN(1), .MEM_TIMEOUT(8), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst),
    .id_src1_i(id_src1), .id_src2_i(id_src2),
    .id_use_src1_i(id_use_src1), .id_use_src2_i(id_use_src2),
    .exe_dest_i(exe_dest), .exe_wb_en_i(exe_wb_en), .exe_mem_r_en_i(exe_mem_r_en),
    .mem_dest_i(mem_dest), .mem_wb_en_i(mem_wb_en),
    .br_taken_i(br_taken), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
    .freeze_fe_o(a_ffe), .bubble_idex_o(a_bub), .flush_o(a_fl),
    .freeze_all_o(a_fa), .mem_err_o(a_err),
    .stall_cnt_o(a_scnt), .flush_cnt_o(a_fcnt)
  );

  hazard_ctrl #(.FWD_EN(0), .MEM_TIMEOUT(64), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst),
    .id_src1_i(id_src1), .id_src2_i(id_src2),
    .id_use_src1_i(id_use_src1), .id_use_src2_i(id_use_src2),
    .exe_dest_i(exe_dest), .exe_wb_en_i(exe_wb_en), .exe_mem_r_en_i(exe_mem_r_en),
    .mem_dest_i(mem_dest), .mem_wb_en_i(mem_wb_en),
    .br_taken_i(br_taken), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
    .freeze_fe_o(b_ffe), .bubble_idex_o(b_bub), .flush_o(b_fl),
    .freeze_all_o(b_fa), .mem_err_o(b_err),
    .stall_cnt_o(b_scnt), .flush_cnt_o(b_fcnt)
  );

  task automatic drive(input stim_t s);
    rst          = s.rst;
    id_src1      = s.s1;
    id_src2      = s.s2;
    id_use_src1  = s.u1;
    id_use_src2  = s.u2;
    exe_dest     = s.ed;
    exe_wb_en    = s.ewb;
    exe_mem_r_en = s.eld;
    mem_dest     = s.md;
    mem_wb_en    = s.mwb;
    br_taken     = s.br;
    mem_req      = s.req;
    mem_ready    = s.rdy;
  endtask

  task automatic do_reset();
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    drive(s);
    @(posedge clk); #1;
    s.rst = 1'b0;
    drive(s);
  endtask

  function automatic stim_t load_use(input logic [3:0] r);
    stim_t s;
    s = '0;
    s.s1 = r; s.u1 = 1'b1; s.ed = r; s.ewb = 1'b1; s.eld = 1'b1;
    return s;
  endfunction

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_run++;
    if ({a_ffe, a_bub, a_fl, a_fa, a_err, a_scnt, a_fcnt} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_a: got ctl=%b err=%b s=%0d f=%0d required all 0",
               {a_ffe, a_bub, a_fl, a_fa}, a_err, a_scnt, a_fcnt);
    end
    n_run++;
    if ({b_ffe, b_bub, b_fl, b_fa, b_err, b_scnt, b_fcnt} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_b: got ctl=%b err=%b s=%0d f=%0d required all 0",
               {b_ffe, b_bub, b_fl, b_fa}, b_err, b_scnt, b_fcnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    stim_t rows[4];
    exp_t  ex[4];
    exp_t  e;
    do_reset();
    rows[0] = load_use(4'd3);                    ex[0] = '{1'b1, 4'b1100, 4'b1100};
    rows[1] = '0;                                ex[1] = '{1'b1, 4'b0000, 4'b0000};
    rows[2] = load_use(4'd3); rows[2].eld = 1'b0; ex[2] = '{1'b1, 4'b0000, 4'b1100};
    rows[3] = load_use(4'd3); rows[3].u1 = 1'b0;  ex[3] = '{1'b1, 4'b0000, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      drive(rows[i]);
      sb_q.push_back(ex[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      n_run++;
      if ({a_ffe, a_bub, a_fl, a_fa} !== e.a || {b_ffe, b_bub, b_fl, b_fa} !== e.b) begin
        n_fail++;
        $display("FAIL load_use[%0d]: got a=%b b=%b required a=%b b=%b", i,
                 {a_ffe, a_bub, a_fl, a_fa}, {b_ffe, b_bub, b_fl, b_fa}, e.a, e.b);
      end
      @(posedge clk); #1;
    end
    n_run++;
    if (a_scnt !== 4'd1 || b_scnt !== 16'd2) begin
      n_fail++;
      $display("FAIL load_use_cnt: got a=%0d b=%0d required a=1 b=2", a_scnt, b_scnt);
    end
  endtask

  task automatic test_raw_mem();
    stim_t rows[4];
    exp_t  ex[4];
    exp_t  e;
    rows[0] = '0; rows[0].s2 = 4'd5; rows[0].u2 = 1'b1; rows[0].md = 4'd5; rows[0].mwb = 1'b1;
    ex[0] = '{1'b1, 4'b0000, 4'b1100};
    rows[1] = rows[0]; rows[1].mwb = 1'b0;
    ex[1] = '{1'b1, 4'b0000, 4'b0000};
    rows[2] = '0; rows[2].s2 = 4'd7; rows[2].u2 = 1'b1; rows[2].ed = 4'd7;
    rows[2].ewb = 1'b1; rows[2].eld = 1'b1;
    ex[2] = '{1'b1, 4'b1100, 4'b1100};
    rows[3] = load_use(4'd2); rows[3].ewb = 1'b0;
    ex[3] = '{1'b1, 4'b0000, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      drive(rows[i]);
      sb_q.push_back(ex[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      n_run++;
      if ({a_ffe, a_bub, a_fl, a_fa} !== e.a || {b_ffe, b_bub, b_fl, b_fa} !== e.b) begin
        n_fail++;
        $display("FAIL raw_mem[%0d]: got a=%b b=%b required a=%b b=%b", i,
                 {a_ffe, a_bub, a_fl, a_fa}, {b_ffe, b_bub, b_fl, b_fa}, e.a, e.b);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    stim_t rows[2];
    exp_t  ex[2];
    exp_t  e;
    do_reset();
    rows[0] = load_use(4'd3); rows[0].br = 1'b1; ex[0] = '{1'b1, 4'b0010, 4'b0010};
    rows[1] = '0;                                ex[1] = '{1'b1, 4'b0000, 4'b0000};
    for (int i = 0; i < 2; i++) begin
      drive(rows[i]);
      sb_q.push_back(ex[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      n_run++;
      if ({a_ffe, a_bub, a_fl, a_fa} !== e.a || {b_ffe, b_bub, b_fl, b_fa} !== e.b) begin
        n_fail++;
        $display("FAIL branch[%0d]: got a=%b b=%b required a=%b b=%b", i,
                 {a_ffe, a_bub, a_fl, a_fa}, {b_ffe, b_bub, b_fl, b_fa}, e.a, e.b);
      end
      @(posedge clk); #1;
    end
    n_run++;
    if (a_fcnt !== 4'd1 || a_scnt !== 4'd0) begin
      n_fail++;
      $display("FAIL branch_cnt: got flush=%0d stall=%0d required flush=1 stall=0",
               a_fcnt, a_scnt);
    end
  endtask

  task automatic test_mem_wait();
    stim_t rows[7];
    exp_t  ex[7];
    exp_t  e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rows[i] = '0; rows[i].req = 1'b1; rows[i].br = 1'b1;
      ex[i] = '{1'b1, 4'b0001, 4'b0001};
    end
    rows[1] = load_use(4'd4); rows[1].req = 1'b1; rows[1].br = 1'b1;
    rows[4] = '0; rows[4].req = 1'b1; rows[4].rdy = 1'b1; rows[4].br = 1'b1;
    ex[4] = '{1'b1, 4'b0010, 4'b0010};
    rows[5] = '0;
    ex[5] = '{1'b1, 4'b0000, 4'b0000};
    rows[6] = '0; rows[6].req = 1'b1; rows[6].rdy = 1'b1;
    ex[6] = '{1'b1, 4'b0000, 4'b0000};
    for (int i = 0; i < 7; i++) begin
      drive(rows[i]);
      sb_q.push_back(ex[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      n_run++;
      if ({a_ffe, a_bub, a_fl, a_fa} !== e.a || {b_ffe, b_bub, b_fl, b_fa} !== e.b) begin
        n_fail++;
        $display("FAIL mem_wait[%0d]: got a=%b b=%b required a=%b b=%b", i,
                 {a_ffe, a_bub, a_fl, a_fa}, {b_ffe, b_bub, b_fl, b_fa}, e.a, e.b);
      end
      @(posedge clk); #1;
    end
    n_run++;
    if (a_scnt !== 4'd4 || a_fcnt !== 4'd1) begin
      n_fail++;
      $display("FAIL mem_wait_cnt: got stall=%0d flush=%0d required stall=4 flush=1",
               a_scnt, a_fcnt);
    end
  endtask

  task automatic test_timeout();
    stim_t rows[13];
    exp_t  ex[13];
    exp_t  e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      rows[i] = '0; rows[i].req = 1'b1;
      ex[i] = '{1'b1, 4'b0001, 4'b0001};
    end
    rows[8]  = '0; rows[8].req = 1'b1;  ex[8]  = '{1'b1, 4'b0000, 4'b0001};
    rows[9]  = '0;                      ex[9]  = '{1'b1, 4'b0000, 4'b0001};
    rows[10] = '0; rows[10].req = 1'b1; ex[10] = '{1'b1, 4'b0001, 4'b0001};
    rows[11] = '0; rows[11].rst = 1'b1; ex[11] = '{1'b0, 4'b0000, 4'b0000};
    rows[12] = '0;                      ex[12] = '{1'b1, 4'b0000, 4'b0000};
    for (int i = 0; i < 13; i++) begin
      drive(rows[i]);
      sb_q.push_back(ex[i]);
      @(negedge clk);
      e = sb_q.pop_front();
      if (e.chk) begin
        n_run++;
        if ({a_ffe, a_bub, a_fl, a_fa} !== e.a || {b_ffe, b_bub, b_fl, b_fa} !== e.b) begin
          n_fail++;
          $display("FAIL timeout[%0d]: got a=%b b=%b required a=%b b=%b", i,
                   {a_ffe, a_bub, a_fl, a_fa}, {b_ffe, b_bub, b_fl, b_fa}, e.a, e.b);
        end
      end
      if (i == 9) begin
        n_run++;
        if (a_err !== 1'b1 || b_err !== 1'b0) begin
          n_fail++;
          $display("FAIL timeout_err: got a=%b b=%b required a=1 b=0", a_err, b_err);
        end
      end
      @(posedge clk); #1;
    end
    n_run++;
    if (a_err !== 1'b0 || b_err !== 1'b0 || a_scnt !== 4'd0) begin
      n_fail++;
      $display("FAIL timeout_rst: got err_a=%b err_b=%b stall=%0d required 0 0 0",
               a_err, b_err, a_scnt);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(load_use(4'(i)));
      sb_q.push_back('{1'b1, 4'b1100, 4'b1100});
      @(negedge clk);
      e = sb_q.pop_front();
      n_run++;
      if ({a_ffe, a_bub, a_fl, a_fa} !== e.a || {b_ffe, b_bub, b_fl, b_fa} !== e.b) begin
        n_fail++;
        $display("FAIL saturation[%0d]: got a=%b b=%b required a=%b b=%b", i,
                 {a_ffe, a_bub, a_fl, a_fa}, {b_ffe, b_bub, b_fl, b_fa}, e.a, e.b);
      end
      @(posedge clk); #1;
    end
    n_run++;
    if (a_scnt !== 4'd15 || b_scnt !== 16'd20) begin
      n_fail++;
      $display("FAIL saturation_cnt: got a=%0d b=%0d required a=15 b=20", a_scnt, b_scnt);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive('0);
    #1;
    test_reset();
    test_load_use();
    test_raw_mem();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule : tb_hazard_ctrl
`default_nettype wire
